mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Shares one 2:1 data multiplexer between two requesters (e.g. two switch groups) and drives its select line.
- Round-robin arbitration with a bounded hold time, so neither requester starves.
- The registered output feeds the LEDG/LEDR display path at board top level.

Parameters:
- W, 1, data width of each requester input and of dout.
- HOLD_MAX, 8, max consecutive grant cycles while the other requester waits; legal range >=2.
- CW, $clog2(HOLD_MAX), hold counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  2  request bits; req[i] high = requester i wants the mux
- din0  input  W  requester 0 data (mux input i[0])
- din1  input  W  requester 1 data (mux input i[1])
- gnt  output  2  one-hot grant, 00 when idle
- sel  output  1  mux select, 0 = din0, 1 = din1
- dout  output  W  registered mux output
- dout_vld  output  1  dout carries granted data
- hold_cnt  output  CW  cycles the current grant has been held (debug/LED)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Asserting rst at any time, including mid-grant, clears all state immediately without waiting for clk.
- Reset values: state=IDLE, gnt=00, sel=0, dout=0, dout_vld=0, hold_cnt=0, last=1. With last=1, requester 0 wins the first tie.
- States: IDLE, G0, G1. gnt is decoded from state: G0 gives 01, G1 gives 10, IDLE gives 00.
- IDLE:
  - req=00: stay.
  - req=01: go to G0.
  - req=10: go to G1.
  - req=11: go to G(~last).
  - gnt rises one cycle after req is sampled high.
- Entering Gx: sel<=x and hold_cnt<=0 on the same edge.
- In Gx, each cycle:
  - req[x]=0: release and set last<=x. If req[~x]=1, go directly to G(~x) with no IDLE bubble; otherwise go to IDLE.
  - req[x]=1, req[~x]=1, hold_cnt==HOLD_MAX-1: preempt to G(~x), last<=x, hold_cnt<=0.
  - req[x]=1, otherwise: stay; hold_cnt increments and saturates at HOLD_MAX-1, never wrapping.
- Datapath:
  - Every edge in Gx, dout<=(sel ? din1 : din0).
  - dout_vld<=1 while in G0/G1, 0 in IDLE.
  - Latency: data on din at cycle t appears on dout at t+1.
  - In IDLE, dout holds its last value with dout_vld=0.
- sel keeps its last value in IDLE and changes only on entry to a G state.
- Simultaneous events: a release and a preemption condition in the same cycle are both resolved as "go to other". req changes during IDLE->G transitions are sampled only at the edge.
- The mux is pure combinational logic inside the sub-module. The only register stage is dout.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_G0=2'd1, ST_G1=2'd2; the default HOLD_MAX.
- Sub-module mux2_path: combinational W-bit 2:1 mux (i0, i1, sel -> y), written at gate level and instantiated once.
- The FSM, hold counter and dout register live in mux2_rr_arbiter.

Test Plan:
- Reset: after rst release, gnt=00, sel=0, dout=0, dout_vld=0, hold_cnt=0. Asserting rst mid-G1 clears gnt to 00 before the next clk edge.
- Single requester: req=01, din0=1 -> gnt=01 at +1 cycle and dout=1, dout_vld=1 at +2. Dropping req -> IDLE, gnt=00, dout_vld=0 at +1.
- Tie from reset: req=11 -> G0 first. req[0] drops after 3 cycles -> G1 on the next edge with no IDLE cycle; sel=1 and dout follows din1.
- Starvation bound: req=11 held, HOLD_MAX=8 -> grants alternate 01 for 8 cycles, then 10 for 8 cycles; hold_cnt runs 0..7 per grant.
- Saturation: only req[1]=1 for 20 cycles -> gnt=10 throughout, hold_cnt sticks at 7, no spurious switch.
- Round-robin memory: G1 released to IDLE, later req=11 -> G0 is granted (last=1).

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
//   state_t          : arbiter state encoding (IDLE / grant to 0 / grant to 1)
//   HOLD_MAX_DEFAULT : default bound on consecutive grant cycles under contention
//   grant_state()    : grant state for a given requester index
//   grant_vec()      : one-hot grant vector for a given requester index
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  localparam int unsigned HOLD_MAX_DEFAULT = 8;

  // Grant state owned by requester 'side'
  function automatic state_t grant_state(input logic side);
    return side ? ST_G1 : ST_G0;
  endfunction

  // One-hot grant vector for requester 'side'
  function automatic logic [1:0] grant_vec(input logic side);
    return side ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_path.sv
// Combinational W-bit 2:1 data mux built from gate primitives.
//   i0  : data selected when sel = 0
//   i1  : data selected when sel = 1
//   sel : select line
//   y   : selected data (no register stage here)
module mux2_path #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic         sel,
  output logic [W-1:0] y
);

  logic         sel_n;
  logic [W-1:0] t0;
  logic [W-1:0] t1;

  not u_inv (sel_n, sel);

  // Per bit: y = (i0 & ~sel) | (i1 & sel)
  for (genvar b = 0; b < W; b++) begin : g_bit
    and u_and0 (t0[b], i0[b], sel_n);
    and u_and1 (t1[b], i1[b], sel);
    or  u_or   (y[b],  t0[b], t1[b]);
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two requesters, with
// a bounded hold time so a contending requester never starves.
//   clk      : system clock, all state on the rising edge
//   rst      : asynchronous active-high reset
//   req      : request bits, req[i] = requester i wants the mux
//   din0     : requester 0 data
//   din1     : requester 1 data
//   gnt      : one-hot grant, 00 when idle
//   sel      : mux select, 0 = din0, 1 = din1
//   dout     : registered mux output
//   dout_vld : dout carries granted data
//   hold_cnt : cycles the current grant has been held
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned W        = 1,
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
  localparam int unsigned CW      = $clog2(HOLD_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [W-1:0]  din0,
  input  logic [W-1:0]  din1,
  output logic [1:0]    gnt,
  output logic          sel,
  output logic [W-1:0]  dout,
  output logic          dout_vld,
  output logic [CW-1:0] hold_cnt
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  state_t       state;
  logic         last;
  logic         cur;
  logic         own_req;
  logic         oth_req;
  logic         at_max;
  logic         leave;
  logic         pick_side;
  logic [W-1:0] mux_y;

  mux2_path #(.W(W)) u_path (
    .i0  (din0),
    .i1  (din1),
    .sel (sel),
    .y   (mux_y)
  );

  // Requester currently holding the grant and its view of both requests
  assign cur     = (state == ST_G1);
  assign own_req = req[cur];
  assign oth_req = req[~cur];
  assign at_max  = (hold_cnt == HOLD_LAST);

  // Release or hold-time expiry under contention both hand the grant over
  assign leave = ~own_req | (oth_req & at_max);

  // From IDLE: a lone request wins; a tie goes to whoever was not served last
  assign pick_side = req[1] & (~req[0] | ~last);

  // Arbiter FSM, hold counter and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= 2'b00;
      sel      <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      hold_cnt <= '0;
      last     <= 1'b1;
    end else begin
      dout_vld <= (state != ST_IDLE);
      if (state != ST_IDLE) begin
        dout <= mux_y;
      end

      case (state)
        ST_IDLE: begin
          if (|req) begin
            state    <= grant_state(pick_side);
            gnt      <= grant_vec(pick_side);
            sel      <= pick_side;
            hold_cnt <= '0;
          end
        end

        ST_G0, ST_G1: begin
          if (leave) begin
            last <= cur;
            if (oth_req) begin
              state    <= grant_state(~cur);
              gnt      <= grant_vec(~cur);
              sel      <= ~cur;
              hold_cnt <= '0;
            end else begin
              state    <= ST_IDLE;
              gnt      <= 2'b00;
              hold_cnt <= '0;
            end
          end else if (!at_max) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end

        default: begin
          state    <= ST_IDLE;
          gnt      <= 2'b00;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_mux2_rr_arbiter;

  localparam int unsigned TW  = 4;
  localparam int unsigned HM  = 8;
  localparam int unsigned HCW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [1:0]     req = 2'b00;
  logic [TW-1:0]  din0 = '0;
  logic [TW-1:0]  din1 = '0;
  logic [1:0]     gnt;
  logic           sel;
  logic [TW-1:0]  dout;
  logic           dout_vld;
  logic [HCW-1:0] hold_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: owner -1 = nobody, else requester index
  int            m_owner;
  int            m_cnt;
  int            m_last;
  logic          m_sel;
  logic [TW-1:0] m_dout;
  logic          m_vld;

  typedef struct {
    logic [1:0]     req;
    logic [TW-1:0]  d0;
    logic [TW-1:0]  d1;
    logic [1:0]     gnt;
    logic           sel;
    logic [TW-1:0]  dout;
    logic           vld;
    logic [HCW-1:0] hold;
  } vec_t;

  vec_t tbl[14];

  mux2_rr_arbiter #(.W(TW), .HOLD_MAX(HM)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din0     (din0),
    .din1     (din1),
    .gnt      (gnt),
    .sel      (sel),
    .dout     (dout),
    .dout_vld (dout_vld),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 1;
    m_sel   = 1'b0;
    m_dout  = '0;
    m_vld   = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] r, input logic [TW-1:0] a, input logic [TW-1:0] b);
    int nxt;
    int other;
    m_vld = (m_owner >= 0);
    if (m_owner == 0) m_dout = a;
    else if (m_owner == 1) m_dout = b;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (r == 2'b01) nxt = 0;
      else if (r == 2'b10) nxt = 1;
      else if (r == 2'b11) nxt = 1 - m_last;
    end else begin
      other = 1 - m_owner;
      if (!r[m_owner] || (r[other] && m_cnt == HM - 1)) begin
        m_last = m_owner;
        nxt = r[other] ? other : -1;
      end
    end
    if (nxt < 0) m_cnt = 0;
    else if (nxt != m_owner) begin
      m_cnt = 0;
      m_sel = (nxt == 1);
    end else m_cnt = (m_cnt + 1 > HM - 1) ? HM - 1 : m_cnt + 1;
    m_owner = nxt;
  endtask

  task automatic check_model(input string tag);
    logic [1:0] eg;
    eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    chk({tag, " gnt"},  32'(gnt),      32'(eg));
    chk({tag, " sel"},  32'(sel),      32'(m_sel));
    chk({tag, " dout"}, 32'(dout),     32'(m_dout));
    chk({tag, " vld"},  32'(dout_vld), 32'(m_vld));
    chk({tag, " hold"}, 32'(hold_cnt), 32'(m_cnt));
  endtask

  // Apply inputs, take one edge, advance the model, settle before checks
  task automatic cycle(input logic [1:0] r, input logic [TW-1:0] a, input logic [TW-1:0] b);
    req  = r;
    din0 = a;
    din1 = b;
    @(posedge clk);
    model_step(r, a, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = 2'b00;
    din0 = '0;
    din1 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  initial begin
    logic [1:0] r;
    // req, d0, d1 -> gnt, sel, dout, vld, hold (expected after the edge)
    tbl[0]  = '{2'b00, 4'h5, 4'hA, 2'b00, 1'b0, 4'h0, 1'b0, 3'd0};
    tbl[1]  = '{2'b01, 4'h3, 4'hA, 2'b01, 1'b0, 4'h0, 1'b0, 3'd0};
    tbl[2]  = '{2'b01, 4'h6, 4'hA, 2'b01, 1'b0, 4'h6, 1'b1, 3'd1};
    tbl[3]  = '{2'b00, 4'h9, 4'hA, 2'b00, 1'b0, 4'h9, 1'b1, 3'd0};
    tbl[4]  = '{2'b00, 4'h1, 4'hA, 2'b00, 1'b0, 4'h9, 1'b0, 3'd0};
    tbl[5]  = '{2'b11, 4'h2, 4'h7, 2'b10, 1'b1, 4'h9, 1'b0, 3'd0};
    tbl[6]  = '{2'b11, 4'h2, 4'h7, 2'b10, 1'b1, 4'h7, 1'b1, 3'd1};
    tbl[7]  = '{2'b01, 4'h4, 4'h8, 2'b01, 1'b0, 4'h8, 1'b1, 3'd0};
    tbl[8]  = '{2'b11, 4'h4, 4'h8, 2'b01, 1'b0, 4'h4, 1'b1, 3'd1};
    tbl[9]  = '{2'b10, 4'hC, 4'hD, 2'b10, 1'b1, 4'hC, 1'b1, 3'd0};
    tbl[10] = '{2'b00, 4'hC, 4'hE, 2'b00, 1'b1, 4'hE, 1'b1, 3'd0};
    tbl[11] = '{2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 4'hE, 1'b0, 3'd0};
    tbl[12] = '{2'b11, 4'hF, 4'h1, 2'b01, 1'b0, 4'hE, 1'b0, 3'd0};
    tbl[13] = '{2'b00, 4'hB, 4'h1, 2'b00, 1'b0, 4'hB, 1'b1, 3'd0};

    // Reset values
    do_reset();
    chk("rst gnt",  32'(gnt),      32'd0);
    chk("rst sel",  32'(sel),      32'd0);
    chk("rst dout", 32'(dout),     32'd0);
    chk("rst vld",  32'(dout_vld), 32'd0);
    chk("rst hold", 32'(hold_cnt), 32'd0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].req, tbl[i].d0, tbl[i].d1);
      chk($sformatf("vec%0d gnt", i),  32'(gnt),      32'(tbl[i].gnt));
      chk($sformatf("vec%0d sel", i),  32'(sel),      32'(tbl[i].sel));
      chk($sformatf("vec%0d dout", i), 32'(dout),     32'(tbl[i].dout));
      chk($sformatf("vec%0d vld", i),  32'(dout_vld), 32'(tbl[i].vld));
      chk($sformatf("vec%0d hold", i), 32'(hold_cnt), 32'(tbl[i].hold));
    end

    // Starvation bound: grants alternate every HM cycles under constant contention
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      cycle(2'b11, TW'($urandom), TW'($urandom));
      chk($sformatf("starve%0d gnt", k), 32'(gnt),
          (((k - 1) / HM) % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("starve%0d hold", k), 32'(hold_cnt), 32'((k - 1) % HM));
      chk($sformatf("starve%0d dout", k), 32'(dout), 32'(m_dout));
    end

    // Saturation: a lone requester keeps the grant, counter sticks at HM-1
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle(2'b10, TW'($urandom), TW'($urandom));
      chk($sformatf("sat%0d gnt", k),  32'(gnt),      32'd2);
      chk($sformatf("sat%0d hold", k), 32'(hold_cnt), (k - 1 < HM - 1) ? 32'(k - 1) : 32'(HM - 1));
    end

    // Tie from reset goes to 0; dropping req[0] hands over with no idle bubble
    do_reset();
    cycle(2'b11, 4'h3, 4'h5);
    chk("tie first gnt", 32'(gnt), 32'd1);
    cycle(2'b11, 4'h3, 4'h5);
    cycle(2'b11, 4'h3, 4'h5);
    cycle(2'b10, 4'h1, 4'h9);
    chk("handover gnt", 32'(gnt), 32'd2);
    chk("handover sel", 32'(sel), 32'd1);
    chk("handover vld", 32'(dout_vld), 32'd1);
    cycle(2'b10, 4'h0, 4'h6);
    chk("handover dout", 32'(dout), 32'h6);

    // Asynchronous reset in the middle of a G1 grant
    do_reset();
    cycle(2'b10, 4'h2, 4'h7);
    cycle(2'b10, 4'h2, 4'h7);
    chk("pre-async gnt", 32'(gnt), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async gnt",  32'(gnt),      32'd0);
    chk("async sel",  32'(sel),      32'd0);
    chk("async dout", 32'(dout),     32'd0);
    chk("async vld",  32'(dout_vld), 32'd0);
    chk("async hold", 32'(hold_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;

    // Randomized traffic with sticky requests so hold expiry is exercised
    r = 2'b11;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 9) == 0) r = 2'($urandom_range(0, 3));
      cycle(r, TW'($urandom), TW'($urandom));
      check_model($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
